// File: rtl/i2s_rx.sv
// I2S receiver: oversamples the I2S bit clock, word select and data with the
// system clock, deserialises one DATA_W-bit word per channel (MSB first) and
// presents each complete left/right pair with a one-cycle valid pulse. Slots
// that end before DATA_W bits have been captured raise a one-cycle error.
`timescale 1ns/1ps

module i2s_rx #(
    parameter int DATA_W = 16
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_sclk,
    input  logic              i_lrck,
    input  logic              i_sdata,
    output logic [DATA_W-1:0] o_left,
    output logic [DATA_W-1:0] o_right,
    output logic              o_valid,
    output logic              o_err
);

    localparam int CNT_W = $clog2(DATA_W + 1);

    typedef enum logic [1:0] {
        SYNC,
        LEFT,
        RIGHT
    } state_t;

    state_t state, next_state;

    // Synchronizer and edge-detect history.
    logic sclk_meta, sclk_s2, sclk_prev;
    logic lrck_meta, lrck_s2, lrck_prev;
    logic sdata_meta, sdata_s2;

    // Deserialiser.
    logic [DATA_W-1:0] shift_reg;
    logic [CNT_W-1:0]  bit_cnt;
    logic              word_done;

    // Pairing.
    logic [DATA_W-1:0] hold_left;
    logic              left_ok;

    // FSM decisions, registered by the datapath block.
    logic set_left_ok, clr_left_ok, load_hold, load_out, err_pulse;

    logic rise, change;

    // A rising sclk edge is the only point at which lrck/sdata are looked at;
    // a change edge is a rising edge where lrck differs from the previous one.
    assign rise   = sclk_s2 & ~sclk_prev;
    assign change = rise & (lrck_s2 ^ lrck_prev);

    // Two-flop synchronizers for the asynchronous I2S inputs plus sclk history.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            sclk_meta  <= 1'b0;
            sclk_s2    <= 1'b0;
            sclk_prev  <= 1'b0;
            lrck_meta  <= 1'b0;
            lrck_s2    <= 1'b0;
            sdata_meta <= 1'b0;
            sdata_s2   <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments make every flop sample the
            // pre-edge value, which is what turns this into a real two-stage
            // chain instead of one flop with a wire behind it.
            sclk_meta  <= i_sclk;
            sclk_s2    <= sclk_meta;
            sclk_prev  <= sclk_s2;
            lrck_meta  <= i_lrck;
            lrck_s2    <= lrck_meta;
            sdata_meta <= i_sdata;
            sdata_s2   <= sdata_meta;
        end
    end

    // Shift in one bit per sclk edge; the change-edge bit is dropped and the
    // counter saturates so trailing slot bits are ignored.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            lrck_prev <= 1'b0;
            shift_reg <= '0;
            bit_cnt   <= '0;
            word_done <= 1'b0;
        end else begin
            word_done <= 1'b0;
            if (rise) begin
                lrck_prev <= lrck_s2;
                if (change) begin
                    bit_cnt <= '0;
                end else if (bit_cnt != CNT_W'(DATA_W)) begin
                    shift_reg <= {shift_reg[DATA_W-2:0], sdata_s2};
                    bit_cnt   <= bit_cnt + 1'b1;
                    word_done <= (bit_cnt == CNT_W'(DATA_W - 1));
                end
            end
        end
    end

    // FSM state register.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state <= SYNC;
        end else begin
            state <= next_state;
        end
    end

    // Next-state and per-cycle decisions; only change edges move the state.
    always_comb begin
        // NOTE: every output of this block gets a default first so no path
        // through the case leaves a value unassigned (which would be a latch).
        next_state  = state;
        set_left_ok = 1'b0;
        clr_left_ok = 1'b0;
        load_hold   = 1'b0;
        load_out    = 1'b0;
        err_pulse   = 1'b0;
        unique case (state)
            SYNC: begin
                if (change && !lrck_s2) begin
                    next_state = LEFT;
                end
            end
            LEFT: begin
                if (word_done) begin
                    load_hold   = 1'b1;
                    set_left_ok = 1'b1;
                end
                if (change && lrck_s2) begin
                    next_state = RIGHT;
                    if (!left_ok) begin
                        err_pulse   = 1'b1;
                        clr_left_ok = 1'b1;
                    end
                end
            end
            RIGHT: begin
                if (word_done && left_ok) begin
                    load_out = 1'b1;
                end
                if (change && !lrck_s2) begin
                    next_state  = LEFT;
                    clr_left_ok = 1'b1;
                    if (bit_cnt != CNT_W'(DATA_W)) begin
                        err_pulse = 1'b1;
                    end
                end
            end
            default: next_state = SYNC;
        endcase
    end

    // Hold register, pairing flag and registered outputs.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            hold_left <= '0;
            left_ok   <= 1'b0;
            o_left    <= '0;
            o_right   <= '0;
            o_valid   <= 1'b0;
            o_err     <= 1'b0;
        end else begin
            o_valid <= load_out;
            o_err   <= err_pulse;
            if (load_hold) begin
                hold_left <= shift_reg;
            end
            if (set_left_ok) begin
                left_ok <= 1'b1;
            end else if (clr_left_ok) begin
                left_ok <= 1'b0;
            end
            if (load_out) begin
                o_left  <= hold_left;
                o_right <= shift_reg;
            end
        end
    end

endmodule

// File: tb/tb_i2s_rx.sv
// Testbench for i2s_rx: drives I2S frames at sclk = clk/8 with 32-bit slots,
// pushes each expected left/right pair to a scoreboard and compares it when
// o_valid pulses. Also tracks error pulses, valid latency and pulse spacing.
`timescale 1ns/1ps

module tb_i2s_rx;

    localparam int DATA_W    = 16;
    localparam int SCLK_HALF = 4;
    localparam int SLOT      = 32;
    localparam int FRAME_CYC = 2 * SLOT * 2 * SCLK_HALF;

    logic              i_clk = 1'b0;
    logic              i_rst;
    logic              i_sclk;
    logic              i_lrck;
    logic              i_sdata;
    logic [DATA_W-1:0] o_left;
    logic [DATA_W-1:0] o_right;
    logic              o_valid;
    logic              o_err;

    i2s_rx #(.DATA_W(DATA_W)) dut (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_sclk  (i_sclk),
        .i_lrck  (i_lrck),
        .i_sdata (i_sdata),
        .o_left  (o_left),
        .o_right (o_right),
        .o_valid (o_valid),
        .o_err   (o_err)
    );

    always #5 i_clk = ~i_clk;

    int unsigned cyc = 0;
    always @(posedge i_clk) cyc <= cyc + 1;

    typedef struct {
        logic [DATA_W-1:0] l;
        logic [DATA_W-1:0] r;
    } pair_t;

    typedef struct {
        logic [DATA_W-1:0] l;
        logic [DATA_W-1:0] r;
        int                left_periods;
        bit                exp_valid;
    } vec_t;

    pair_t       sb[$];
    int unsigned valid_cycs[$];
    int unsigned last_rise_cyc = 0;
    int          checks = 0;
    int          errors = 0;
    int          err_pulses = 0;
    pair_t       exp_pair;
    logic [DATA_W-1:0] prev_l = '0;
    logic [DATA_W-1:0] prev_r = '0;
    vec_t        vec[11];
    int          err_before;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // One sclk period: lrck/data change with the falling edge, DUT samples on the rise.
    task automatic sclk_period(input logic lr, input logic d, input bit mark);
        i_sclk  = 1'b0;
        i_lrck  = lr;
        i_sdata = d;
        repeat (SCLK_HALF) @(negedge i_clk);
        i_sclk = 1'b1;
        if (mark) last_rise_cyc = cyc;
        repeat (SCLK_HALF) @(negedge i_clk);
    endtask

    // Periods k_from..k_to of a slot; period 0 is the change edge, 1..DATA_W carry data.
    task automatic send_slot(input logic lr, input logic [DATA_W-1:0] w,
                             input int k_from, input int k_to);
        for (int k = k_from; k <= k_to; k++) begin
            logic d;
            if (k >= 1 && k <= DATA_W) d = w[DATA_W-k];
            else                       d = 1'($urandom_range(0, 1));
            sclk_period(lr, d, lr && (k == DATA_W));
        end
    endtask

    // Scoreboard / protocol monitor, sampled away from the active edge.
    always @(negedge i_clk) begin
        if (o_valid) begin
            valid_cycs.push_back(cyc);
            check("valid_err_excl", 32'(o_err), 32'd0);
            check("valid_latency", cyc - last_rise_cyc, 32'd4);
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_valid: got pulse L=%h R=%h, expected none", o_left, o_right);
            end else begin
                exp_pair = sb.pop_front();
                check("left", 32'(o_left), 32'(exp_pair.l));
                check("right", 32'(o_right), 32'(exp_pair.r));
            end
        end
        if (o_err) err_pulses++;
        if (!i_rst && (o_left !== prev_l || o_right !== prev_r))
            check("change_with_valid", 32'(o_valid), 32'd1);
        prev_l = o_left;
        prev_r = o_right;
    end

    initial begin
        vec[0] = '{16'hA55A, 16'h0FF0, SLOT, 1'b1};
        for (int n = 0; n < 8; n++)
            vec[1+n] = '{16'(n), ~16'(n), SLOT, 1'b1};
        vec[9]  = '{16'h1357, 16'h2468, 11, 1'b0};
        vec[10] = '{16'h0001, 16'hFFFF, SLOT, 1'b1};

        // Reset with random inputs.
        i_rst = 1'b1; i_sclk = 1'b0; i_lrck = 1'b0; i_sdata = 1'b0;
        repeat (2) begin
            @(negedge i_clk);
            i_sclk  = 1'($urandom_range(0, 1));
            i_lrck  = 1'($urandom_range(0, 1));
            i_sdata = 1'($urandom_range(0, 1));
        end
        @(negedge i_clk);
        check("rst_left", 32'(o_left), 32'd0);
        check("rst_right", 32'(o_right), 32'd0);
        check("rst_valid", 32'(o_valid), 32'd0);
        check("rst_err", 32'(o_err), 32'd0);
        i_rst  = 1'b0;
        i_sclk = 1'b0;

        // Right slot preamble so the first left slot starts on a change edge.
        send_slot(1'b1, 16'h0000, 0, SLOT-1);

        // Single frame, back-to-back streaming, short left slot, recovery frame.
        valid_cycs.delete();
        for (int i = 0; i < 11; i++) begin
            if (vec[i].exp_valid) sb.push_back('{vec[i].l, vec[i].r});
            send_slot(1'b0, vec[i].l, 0, vec[i].left_periods - 1);
            send_slot(1'b1, vec[i].r, 0, SLOT-1);
        end
        check("table_sb_empty", 32'(sb.size()), 32'd0);
        check("table_err_pulses", 32'(err_pulses), 32'd1);
        check("table_valid_count", 32'(valid_cycs.size()), 32'd10);
        if (valid_cycs.size() >= 9)
            for (int i = 1; i <= 8; i++)
                check("stream_spacing", valid_cycs[i] - valid_cycs[i-1], 32'(FRAME_CYC));

        // Reset released midway through a right slot.
        err_before = err_pulses;
        send_slot(1'b0, 16'hDEAD, 0, SLOT-1);
        send_slot(1'b1, 16'hBEEF, 0, 12);
        i_rst = 1'b1;
        repeat (2) @(negedge i_clk);
        i_rst = 1'b0;
        send_slot(1'b1, 16'hBEEF, 13, SLOT-1);
        sb.push_back('{16'h1234, 16'h5678});
        send_slot(1'b0, 16'h1234, 0, SLOT-1);
        send_slot(1'b1, 16'h5678, 0, SLOT-1);
        sb.push_back('{16'h9ABC, 16'hDEF0});
        send_slot(1'b0, 16'h9ABC, 0, SLOT-1);
        send_slot(1'b1, 16'hDEF0, 0, SLOT-1);
        check("midstart_sb_empty", 32'(sb.size()), 32'd0);
        check("midstart_no_err", 32'(err_pulses - err_before), 32'd0);

        // Reset asserted during left bit 7 of frame 8000/7FFF.
        err_before = err_pulses;
        send_slot(1'b0, 16'h8000, 0, 6);
        i_sclk  = 1'b0;
        i_lrck  = 1'b0;
        i_sdata = 1'b0;
        repeat (SCLK_HALF) @(negedge i_clk);
        i_sclk = 1'b1;
        repeat (2) @(negedge i_clk);
        i_rst = 1'b1;
        @(negedge i_clk);
        check("rstmid_left", 32'(o_left), 32'd0);
        check("rstmid_right", 32'(o_right), 32'd0);
        check("rstmid_valid", 32'(o_valid), 32'd0);
        check("rstmid_err", 32'(o_err), 32'd0);
        @(negedge i_clk);
        i_rst = 1'b0;
        send_slot(1'b0, 16'h8000, 8, SLOT-1);
        send_slot(1'b1, 16'h7FFF, 0, SLOT-1);
        sb.push_back('{16'h8000, 16'h7FFF});
        send_slot(1'b0, 16'h8000, 0, SLOT-1);
        send_slot(1'b1, 16'h7FFF, 0, SLOT-1);
        check("rstmid_sb_empty", 32'(sb.size()), 32'd0);
        check("rstmid_no_err", 32'(err_pulses - err_before), 32'd0);

        repeat (10) @(negedge i_clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/i2s_rx.md
I2S_RX -- requirements
Module: i2s_rx

Interface
REQ-001 SHALL have parameter DATA_W, default 16: bits captured per channel, MSB first.
REQ-002 SHALL have port i_clk, input, 1: single system clock for all logic; nominal 74.25 MHz.
REQ-003 SHALL have port i_rst, input, 1: reset, synchronous, active-high.
REQ-004 SHALL have port i_sclk, input, 1: I2S bit clock, asynchronous to i_clk.
REQ-005 SHALL have port i_lrck, input, 1: I2S word select; 0 = left, 1 = right; asynchronous.
REQ-006 SHALL have port i_sdata, input, 1: I2S serial data; asynchronous.
REQ-007 SHALL have port o_left, output, DATA_W: last complete left sample, raw two's-complement bits.
REQ-008 SHALL have port o_right, output, DATA_W: last complete right sample.
REQ-009 SHALL have port o_valid, output, 1: one-cycle pulse when o_left/o_right update as a pair.
REQ-010 SHALL have port o_err, output, 1: one-cycle pulse on a short-slot framing error.

Function
REQ-011 SHALL pass i_sclk, i_lrck and i_sdata each through a two-flop synchronizer clocked by i_clk before any use.
REQ-012 SHALL detect sclk rising edges as synced sclk = 1 with previous synced sclk = 0; all sampling of lrck and sdata SHALL occur only on these edges.
REQ-013 SHALL support i_clk >= 8x i_sclk, with sclk high and low phases each >= 3 i_clk periods.
REQ-014 SHALL use standard I2S timing: an lrck change seen at an sclk edge (the "change edge") marks a slot start; that edge's data bit SHALL be discarded; the next DATA_W edges carry bits MSB to LSB.
REQ-015 SHALL shift captured bits into a DATA_W shift register MSB first, with a bit counter 0..DATA_W that resets to 0 on each change edge and saturates at DATA_W.
REQ-016 SHALL ignore slot bits after the DATA_W-th bit; slot length SHALL be >= DATA_W+1 sclk periods.
REQ-017 SHALL implement states SYNC, LEFT and RIGHT.
REQ-018 SYNC SHALL ignore data until a change edge with new lrck = 0, then go to LEFT.
REQ-019 LEFT SHALL, when the counter reaches DATA_W, latch the shift register into an internal left hold register and set left_ok.
REQ-020 LEFT SHALL, on a change edge to lrck = 1, go to RIGHT if left_ok = 1; otherwise pulse o_err, clear left_ok and go to RIGHT.
REQ-021 RIGHT SHALL, when the counter reaches DATA_W with left_ok = 1, load o_left from the hold register and o_right from the shift register, and pulse o_valid for one cycle.
REQ-022 RIGHT SHALL, on a change edge to lrck = 0 with fewer than DATA_W right bits captured, pulse o_err; in all cases it SHALL clear left_ok and go to LEFT.
REQ-023 A right word completing with left_ok = 0 SHALL produce no o_valid, and o_left/o_right SHALL hold their values.
REQ-024 Latency: counting edge 1 as the first i_clk edge that samples i_sclk high for the final right bit, the bit SHALL be captured at edge 3, and o_valid SHALL be high for exactly the cycle following edge 4.
REQ-025 o_left and o_right SHALL change only together with an o_valid pulse.
REQ-026 o_valid and o_err SHALL never be high in the same cycle; o_err SHALL not fire for the first change edge after SYNC.
REQ-027 An lrck level seen on an edge that is not a change edge SHALL never alter the state.

Reset
REQ-028 i_rst = 1 at an i_clk edge SHALL clear o_left, o_right, o_valid, o_err, the shift register, the counter, left_ok, the hold register and the synchronizer flops, and SHALL force SYNC; this applies at any point, including mid-slot.
REQ-029 After i_rst deasserts, no o_valid SHALL occur before one full left slot plus one full right slot.

Verification
REQ-030 Reset: hold i_rst 2 cycles with random inputs -> o_left = 0, o_right = 0, o_valid = 0, o_err = 0, state SYNC.
REQ-031 Single frame: sclk = i_clk/8, 32 sclk per slot, L = 16'hA55A, R = 16'h0FF0 -> exactly one o_valid pulse, o_left = A55A, o_right = 0FF0, o_err never high.
REQ-032 Mid-frame start: release reset midway through a right slot, then send two frames (1234/5678, 9ABC/DEF0) -> no pulse for the partial slot; o_valid pulses carry 1234/5678 then 9ABC/DEF0.
REQ-033 Short slot: toggle lrck after 10 left bits, then send a good frame 0001/FFFF -> one o_err pulse and no o_valid for the bad frame; next o_valid gives 0001/FFFF.
REQ-034 Streaming: 8 back-to-back frames, L = n, R = ~n for n = 0..7 -> 8 o_valid pulses spaced exactly 64 sclk periods, values exact and in order.
REQ-035 Reset mid-slot: assert i_rst during left bit 7 of frame 8000/7FFF -> all outputs 0 the next cycle; the following full frame 8000/7FFF is received correctly.
